decimator: RTL and testbench

// - Runtime-configurable sample-rate reducer between the ADC capture path and the sample buffer / UART path.
// - Collapses each block of 2**iLog2_Ratio valid input samples into one output sample.
// - The output sample is chosen by mode: last sample, truncated mean, peak max or peak min.
// - Successor of the fixed-ratio pick-one downsampler: width, ratio range and reduction mode are all parametrised.

---
 rtl/decimator_pkg.sv | 21 ++
 rtl/decimator_fold.sv | 45 ++++
 rtl/decimator.sv | 113 +++++++++++
 tb/tb_decimator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimator_pkg.sv
// ============================================================================
// decimator_pkg : shared mode and state encodings for the decimator block
// Revision      : 1.0
// ============================================================================
`default_nettype none

package decimator_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_PICK_LAST = 2'd0;
   localparam mode_t MODE_AVERAGE   = 2'd1;
   localparam mode_t MODE_PEAK_MAX  = 2'd2;
   localparam mode_t MODE_PEAK_MIN  = 2'd3;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/decimator_fold.sv
// ============================================================================
// decimator_fold : combinational fold of one sample into the block accumulator
// Revision       : 1.0
// ============================================================================
`default_nettype none

module decimator_fold
   import decimator_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_LOG2 = 14
)
(
   input  logic [DATA_W+MAX_LOG2-1:0] acc,
   input  logic [DATA_W-1:0]          sample,
   input  mode_t                      mode,
   input  logic                       first,
   output logic [DATA_W+MAX_LOG2-1:0] acc_next
);

   localparam int ACC_W = DATA_W + MAX_LOG2;

   logic [ACC_W-1:0] sample_ext;

   assign sample_ext = {{MAX_LOG2{1'b0}}, sample};

   // The first sample of a block seeds the accumulator regardless of mode.
   always_comb begin
      acc_next = acc;
      if (first) begin
         acc_next = sample_ext;
      end else begin
         case (mode)
            MODE_PICK_LAST: acc_next = sample_ext;
            MODE_AVERAGE:   acc_next = acc + sample_ext;
            MODE_PEAK_MAX:  acc_next = (sample_ext > acc) ? sample_ext : acc;
            MODE_PEAK_MIN:  acc_next = (sample_ext < acc) ? sample_ext : acc;
            default:        acc_next = acc;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/decimator.sv
// ============================================================================
// decimator : collapses each block of 2**ratio valid samples into one output
// Revision  : 1.0
// ============================================================================
`default_nettype none

module decimator
   import decimator_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_LOG2 = 14,
   parameter int LOG2_W   = 4
)
(
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic [DATA_W-1:0]   iData,
   input  logic                iData_Valid,
   input  logic [LOG2_W-1:0]   iLog2_Ratio,
   input  logic [1:0]          iMode,
   input  logic                iClear,
   output logic [DATA_W-1:0]   oData,
   output logic                oData_Valid,
   output logic [MAX_LOG2:0]   oBlock_Cnt
);

   localparam int ACC_W = DATA_W + MAX_LOG2;
   localparam int CNT_W = MAX_LOG2 + 1;

   localparam logic [LOG2_W-1:0] MAX_LOG2_L = LOG2_W'(MAX_LOG2);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   logic [0:0]        state;
   logic [LOG2_W-1:0] cfg_log2;
   mode_t             cfg_mode;
   logic [CNT_W-1:0]  count;
   logic [ACC_W-1:0]  acc;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   logic [LOG2_W-1:0] in_log2;
   logic [LOG2_W-1:0] eff_log2;
   mode_t             eff_mode;
   logic              first;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  block_len;
   logic [ACC_W-1:0]  acc_next;
   logic [DATA_W-1:0] avg_data;
   logic              complete;

   assign in_log2 = (iLog2_Ratio > MAX_LOG2_L) ? MAX_LOG2_L : iLog2_Ratio;

   // In IDLE the live inputs act as the config so a ratio-1 block can
   // complete on the very sample that opens it.
   assign first      = (state == ST_IDLE);
   assign eff_log2   = first ? in_log2 : cfg_log2;
   assign eff_mode   = first ? iMode : cfg_mode;
   assign count_next = first ? CNT_ONE : count + CNT_ONE;
   assign block_len  = CNT_ONE << eff_log2;
   assign complete   = iData_Valid && !iClear && (count_next == block_len);
   assign avg_data   = DATA_W'(acc_next >> eff_log2);

   decimator_fold #(
      .DATA_W   (DATA_W),
      .MAX_LOG2 (MAX_LOG2)
   ) u_fold (
      .acc      (acc),
      .sample   (iData),
      .mode     (eff_mode),
      .first    (first),
      .acc_next (acc_next)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state    <= ST_IDLE;
         cfg_log2 <= '0;
         cfg_mode <= MODE_PICK_LAST;
         count    <= '0;
         acc      <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (iClear) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (iData_Valid) begin
            acc <= acc_next;
            if (first) begin
               cfg_log2 <= in_log2;
               cfg_mode <= iMode;
            end
            if (complete) begin
               state   <= ST_IDLE;
               count   <= '0;
               valid_q <= 1'b1;
               data_q  <= (eff_mode == MODE_AVERAGE) ? avg_data : acc_next[DATA_W-1:0];
            end else begin
               state <= ST_ACCUM;
               count <= count_next;
            end
         end
      end
   end

   assign oData       = data_q;
   assign oData_Valid = valid_q;
   assign oBlock_Cnt  = count;

endmodule

`default_nettype wire

// File: tb/tb_decimator.sv
// ============================================================================
// tb_decimator : directed and randomized checks of decimator against a model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_decimator;

   logic        iClk        = 1'b0;
   logic        iRst_n      = 1'b0;
   logic [7:0]  iData       = '0;
   logic        iData_Valid = 1'b0;
   logic [3:0]  iLog2_Ratio = '0;
   logic [1:0]  iMode       = '0;
   logic        iClear      = 1'b0;
   logic [7:0]  oData;
   logic        oData_Valid;
   logic [14:0] oBlock_Cnt;

   int total = 0;
   int bad   = 0;

   decimator dut (
      .iClk        (iClk),
      .iRst_n      (iRst_n),
      .iData       (iData),
      .iData_Valid (iData_Valid),
      .iLog2_Ratio (iLog2_Ratio),
      .iMode       (iMode),
      .iClear      (iClear),
      .oData       (oData),
      .oData_Valid (oData_Valid),
      .oBlock_Cnt  (oBlock_Cnt)
   );

   always #5 iClk = ~iClk;

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic step(input logic v, input logic [7:0] d);
      iData_Valid = v;
      iData       = d;
      @(posedge iClk);
      #1;
   endtask

   // Reference reduction of one complete block of samples.
   function automatic int reduce(input int s[$], input int mode, input int l2);
      int r;
      int sum;
      sum = 0;
      r   = s[s.size()-1];
      case (mode)
         1: begin
            foreach (s[k]) sum += s[k];
            r = sum >> l2;
         end
         2: begin
            r = s[0];
            foreach (s[k]) if (s[k] > r) r = s[k];
         end
         3: begin
            r = s[0];
            foreach (s[k]) if (s[k] < r) r = s[k];
         end
         default: r = s[s.size()-1];
      endcase
      return r;
   endfunction

   task automatic test_reset();
      #12;
      total++;
      if (oData !== 8'd0 || oData_Valid !== 1'b0 || oBlock_Cnt !== 15'd0) begin
         bad++;
         $display("FAIL reset_initial got data=%0d valid=%0b cnt=%0d want 0/0/0", oData, oData_Valid, oBlock_Cnt);
      end
      @(posedge iClk); #1;
      iRst_n = 1'b1;
      iMode = 2'd0; iLog2_Ratio = 4'd0;
      step(1'b1, 8'h5A);
      total++;
      if (oData_Valid !== 1'b1 || oData !== 8'h5A) begin
         bad++;
         $display("FAIL reset_preload got valid=%0b data=%0h want 1/5a", oData_Valid, oData);
      end
      iLog2_Ratio = 4'd2;
      step(1'b1, 8'd1);
      step(1'b1, 8'd2);
      total++;
      if (oBlock_Cnt !== 15'd2) begin
         bad++;
         $display("FAIL reset_midblock_cnt got=%0d want=2", oBlock_Cnt);
      end
      iData_Valid = 1'b0;
      #2; iRst_n = 1'b0; #1;
      total++;
      if (oData !== 8'd0 || oData_Valid !== 1'b0 || oBlock_Cnt !== 15'd0) begin
         bad++;
         $display("FAIL reset_async got data=%0d valid=%0b cnt=%0d want 0/0/0", oData, oData_Valid, oBlock_Cnt);
      end
      @(posedge iClk); #1;
      iRst_n = 1'b1;
      step(1'b1, 8'h11);
      total++;
      if (oBlock_Cnt !== 15'd1 || oData_Valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_fresh_block got cnt=%0d valid=%0b want 1/0", oBlock_Cnt, oData_Valid);
      end
      step(1'b1, 8'h22);
      step(1'b1, 8'h33);
      step(1'b1, 8'h44);
      total++;
      if (oData_Valid !== 1'b1 || oData !== 8'h44 || oBlock_Cnt !== 15'd0) begin
         bad++;
         $display("FAIL reset_block_close got valid=%0b data=%0h cnt=%0d want 1/44/0", oData_Valid, oData, oBlock_Cnt);
      end
   endtask

   task automatic test_pick_last();
      int nv;
      nv = 0;
      iMode = 2'd0; iLog2_Ratio = 4'd2;
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 8'(i));
         total++;
         if (oData_Valid !== ((i % 4) == 0)) begin
            bad++;
            $display("FAIL pick_last_strobe i=%0d got=%0b want=%0b", i, oData_Valid, ((i % 4) == 0));
         end
         if (oData_Valid === 1'b1) begin
            nv++;
            total++;
            if (oData !== 8'(i)) begin
               bad++;
               $display("FAIL pick_last_data i=%0d got=%0d want=%0d", i, oData, i);
            end
         end
      end
      step(1'b0, 8'd0);
      total++;
      if (nv != 2 || oData_Valid !== 1'b0) begin
         bad++;
         $display("FAIL pick_last_count got=%0d trailing_valid=%0b want 2/0", nv, oData_Valid);
      end
   endtask

   task automatic test_average();
      int in_a[4];
      in_a = '{10, 11, 12, 14};
      iMode = 2'd1; iLog2_Ratio = 4'd2;
      foreach (in_a[k]) step(1'b1, 8'(in_a[k]));
      total++;
      if (oData_Valid !== 1'b1 || oData !== 8'd11) begin
         bad++;
         $display("FAIL average_trunc got valid=%0b data=%0d want 1/11", oData_Valid, oData);
      end
      repeat (4) step(1'b1, 8'd255);
      total++;
      if (oData_Valid !== 1'b1 || oData !== 8'd255) begin
         bad++;
         $display("FAIL average_full got valid=%0b data=%0d want 1/255", oData_Valid, oData);
      end
   endtask

   task automatic test_peak();
      int in_p[8];
      int nv;
      int want;
      in_p = '{5, 200, 3, 9, 0, 7, 7, 1};
      for (int m = 2; m <= 3; m++) begin
         nv = 0;
         want = (m == 2) ? 200 : 0;
         iMode = 2'(m); iLog2_Ratio = 4'd3;
         foreach (in_p[k]) begin
            step(1'b1, 8'(in_p[k]));
            if (oData_Valid === 1'b1) begin
               nv++;
               total++;
               if (oData !== 8'(want) || k != 7) begin
                  bad++;
                  $display("FAIL peak_data mode=%0d k=%0d got=%0d want=%0d at k=7", m, k, oData, want);
               end
            end
            step(1'b0, 8'hEE);
            if (k != 7) step(1'b0, 8'hEE);
         end
         total++;
         if (nv != 1 || oData !== 8'(want)) begin
            bad++;
            $display("FAIL peak_strobes mode=%0d got strobes=%0d data=%0d want 1/%0d", m, nv, oData, want);
         end
      end
   endtask

   task automatic test_ratio_change();
      iMode = 2'd0; iLog2_Ratio = 4'd2;
      step(1'b1, 8'd1);
      step(1'b1, 8'd2);
      iLog2_Ratio = 4'd0;
      step(1'b1, 8'd3);
      total++;
      if (oData_Valid !== 1'b0 || oBlock_Cnt !== 15'd3) begin
         bad++;
         $display("FAIL ratio_change_hold got valid=%0b cnt=%0d want 0/3", oData_Valid, oBlock_Cnt);
      end
      step(1'b1, 8'd4);
      total++;
      if (oData_Valid !== 1'b1 || oData !== 8'd4) begin
         bad++;
         $display("FAIL ratio_change_close got valid=%0b data=%0d want 1/4", oData_Valid, oData);
      end
      for (int i = 5; i <= 7; i++) begin
         step(1'b1, 8'(i));
         total++;
         if (oData_Valid !== 1'b1 || oData !== 8'(i) || oBlock_Cnt !== 15'd0) begin
            bad++;
            $display("FAIL ratio_one i=%0d got valid=%0b data=%0d cnt=%0d want 1/%0d/0", i, oData_Valid, oData, oBlock_Cnt, i);
         end
      end
   endtask

   task automatic test_clear();
      int nv;
      nv = 0;
      iMode = 2'd0; iLog2_Ratio = 4'd2;
      repeat (3) step(1'b1, 8'd9);
      iClear = 1'b1;
      step(1'b1, 8'd77);
      iClear = 1'b0;
      total++;
      if (oData_Valid !== 1'b0 || oData !== 8'd7 || oBlock_Cnt !== 15'd0) begin
         bad++;
         $display("FAIL clear_discard got valid=%0b data=%0d cnt=%0d want 0/7/0", oData_Valid, oData, oBlock_Cnt);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 8'(20 + i));
         if (oData_Valid === 1'b1) nv++;
      end
      total++;
      if (nv != 1 || oData !== 8'd24) begin
         bad++;
         $display("FAIL clear_next_block got strobes=%0d data=%0d want 1/24", nv, oData);
      end
   endtask

   task automatic test_clamp();
      int nv;
      nv = 0;
      iMode = 2'd0; iLog2_Ratio = 4'd15;
      for (int i = 1; i < 16384; i++) begin
         step(1'b1, 8'(i));
         if (oData_Valid === 1'b1) nv++;
      end
      total++;
      if (nv != 0 || oBlock_Cnt !== 15'd16383) begin
         bad++;
         $display("FAIL clamp_fill got strobes=%0d cnt=%0d want 0/16383", nv, oBlock_Cnt);
      end
      step(1'b1, 8'hC3);
      total++;
      if (oData_Valid !== 1'b1 || oData !== 8'hC3 || oBlock_Cnt !== 15'd0) begin
         bad++;
         $display("FAIL clamp_close got valid=%0b data=%0h cnt=%0d want 1/c3/0", oData_Valid, oData, oBlock_Cnt);
      end
   endtask

   task automatic test_random(input int n, input int prev_data);
      int   q[$];
      int   cur_mode;
      int   cur_l2;
      int   hold;
      logic exp_v;
      logic v;
      int   d;
      cur_mode = 0;
      cur_l2   = 0;
      hold     = prev_data;
      for (int i = 0; i < n; i++) begin
         iMode       = 2'($urandom_range(0, 3));
         iLog2_Ratio = 4'($urandom_range(0, 3));
         iClear      = ($urandom_range(0, 29) == 0);
         v           = ($urandom_range(0, 3) != 0);
         d           = $urandom_range(0, 255);
         exp_v       = 1'b0;
         if (iClear) begin
            q.delete();
         end else if (v) begin
            if (q.size() == 0) begin
               cur_mode = int'(iMode);
               cur_l2   = (iLog2_Ratio > 4'd14) ? 14 : int'(iLog2_Ratio);
            end
            q.push_back(d);
            if (q.size() == (1 << cur_l2)) begin
               exp_v = 1'b1;
               hold  = reduce(q, cur_mode, cur_l2);
               q.delete();
            end
         end
         step(v, 8'(d));
         total++;
         if (oData_Valid !== exp_v || oData !== 8'(hold) || oBlock_Cnt !== 15'(q.size())) begin
            bad++;
            $display("FAIL random cyc=%0d got valid=%0b data=%0d cnt=%0d want %0b/%0d/%0d",
                     i, oData_Valid, oData, oBlock_Cnt, exp_v, hold, q.size());
         end
      end
      iClear = 1'b0;
      iData_Valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_pick_last();
      test_average();
      test_peak();
      test_ratio_change();
      test_clear();
      test_clamp();
      test_random(3000, 8'hC3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
